// File: rtl/serializer_unit_cell_16b.sv
// 16:1 parallel-to-serial transmit cell: captures PAR_IN once per 16-cycle frame
// and shifts it out LSB-first, alongside a free-running 6-bit frame/bit counter.
module serializer_unit_cell_16b (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] PAR_IN,
  output logic        SERIAL_OUT,
  output logic [5:0]  COUNT
);

  logic [5:0]  count_q, count_d;
  logic [15:0] sr_q, sr_d;
  logic        load_frame;

  // A frame boundary is wherever the bit index (low nibble) is zero before the edge.
  assign load_frame = (count_q[3:0] == 4'd0);

  always_comb begin
    count_d = count_q + 6'd1;
    sr_d    = {1'b0, sr_q[15:1]};
    if (load_frame) begin
      sr_d = PAR_IN;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= 6'd0;
      sr_q    <= 16'd0;
    end else begin
      count_q <= count_d;
      sr_q    <= sr_d;
    end
  end

  // Serial bit comes straight off the shift-register flop: no input-to-output path.
  assign SERIAL_OUT = sr_q[0];
  assign COUNT      = count_q;

endmodule

// File: tb/tb_serializer_unit_cell_16b.sv
// Scoreboard bench for serializer_unit_cell_16b: a cycle-indexed reference model
// predicts each bit/count, and a negedge monitor compares the DUT against it.
module tb_serializer_unit_cell_16b;

  logic        CLK;
  logic        RESET;
  logic [15:0] PAR_IN;
  logic        SERIAL_OUT;
  logic [5:0]  COUNT;

  int checks = 0;
  int errors = 0;

  serializer_unit_cell_16b dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .PAR_IN    (PAR_IN),
    .SERIAL_OUT(SERIAL_OUT),
    .COUNT     (COUNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model: edges since reset, word captured at every 16th edge,
  // bit presented after edge k is word[k mod 16], count after edge k is (k+1) mod 64.
  logic [6:0]  sbq[$];
  int          m_cnt;
  logic [15:0] m_word;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_cnt = 0;
      sbq.delete();
    end else begin
      int idx;
      idx = m_cnt % 16;
      if (idx == 0) m_word = PAR_IN;
      sbq.push_back({6'((m_cnt + 1) % 64), m_word[idx]});
      m_cnt++;
    end
  end

  // Monitor: pops one expectation per cycle, away from the active edge.
  logic [5:0] prev_count;
  bit         saw_wrap = 0;

  always @(negedge CLK) begin
    logic [6:0] exp;
    if (RESET) begin
      checks++;
      if (COUNT !== 6'd0 || SERIAL_OUT !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: count=%0d serial=%b required count=0 serial=0", COUNT, SERIAL_OUT);
      end
    end else begin
      exp = (sbq.size() > 0) ? sbq.pop_front() : 7'd0;
      checks++;
      if (COUNT !== exp[6:1] || SERIAL_OUT !== exp[0]) begin
        errors++;
        $display("FAIL stream: count=%0d serial=%b required count=%0d serial=%b",
                 COUNT, SERIAL_OUT, exp[6:1], exp[0]);
      end
      if (prev_count == 6'd63 && COUNT == 6'd0) saw_wrap = 1;
    end
    prev_count = COUNT;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic wait_count(input logic [5:0] mask, input logic [5:0] val, input string name);
    int k;
    k = 0;
    while (((COUNT & mask) != val) && k < 80) begin
      tick(1);
      k++;
    end
    checks++;
    if ((COUNT & mask) != val) begin
      errors++;
      $display("FAIL %s: count=%0d required value %0d within 80 cycles", name, COUNT, val);
    end
  endtask

  task automatic check_async_zero(input string name);
    #1;
    checks++;
    if (COUNT !== 6'd0 || SERIAL_OUT !== 1'b0) begin
      errors++;
      $display("FAIL %s: count=%0d serial=%b required count=0 serial=0", name, COUNT, SERIAL_OUT);
    end
  endtask

  initial begin
    logic [15:0] known;
    known  = 16'hF5A3;
    RESET  = 1'b1;
    PAR_IN = 16'hFFFF;
    check_async_zero("reset_initial");
    tick(2);
    check_async_zero("reset_midcycle");

    // Known word: explicit bit pattern check over two frames.
    PAR_IN = known;
    RESET  = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge CLK);
      if (k > 0) begin
        checks++;
        if (SERIAL_OUT !== known[(k - 1) % 16]) begin
          errors++;
          $display("FAIL known_word bit%0d: serial=%b required %b", (k - 1) % 16, SERIAL_OUT, known[(k - 1) % 16]);
        end
      end
    end
    tick(1);

    // Mid-frame change at bit index 5.
    wait_count(6'h0F, 6'd5, "reach_idx5");
    PAR_IN = 16'($urandom);
    tick(40);

    // Counter wrap.
    tick(70);
    checks++;
    if (!saw_wrap) begin
      errors++;
      $display("FAIL count_wrap: wrap seen=%0d required 1", saw_wrap);
    end

    // Random words separated by zero gaps.
    for (int w = 0; w < 10; w++) begin
      PAR_IN = 16'($urandom);
      tick(50);
      PAR_IN = 16'h0000;
      tick(7);
    end

    // Reset mid-frame at COUNT==9.
    PAR_IN = 16'($urandom);
    wait_count(6'h3F, 6'd9, "reach_count9");
    RESET = 1'b1;
    check_async_zero("reset_midframe");
    tick(2);
    PAR_IN = 16'($urandom);
    RESET  = 1'b0;
    tick(40);

    @(negedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
